rob_commit_sequencer: RTL and testbench

- Sits at the ROB head and drives the commit-side interfaces consumed by the hazard controller: valid_commit, branch commit (valid_branch, branch_outcome) and jump-register commit (valid_jump_reg, jump_target).
- Retires at most one instruction per cycle and enforces MIPS delay-slot ordering.
- After a mispredicted branch or any JR, it freezes retirement until the hazard controller's flush arrives, so no wrong-path instruction ever commits.

---
 rtl/rob_commit_sequencer_pkg.sv | 24 ++
 rtl/rob_commit_sequencer.sv | 134 +++++++++++++
 tb/tb_rob_commit_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/rob_commit_sequencer_pkg.sv
// Shared types and constants for the ROB commit sequencer: commit-state
// encoding, branch outcome encoding and the default PC / ROB tag widths.
package rob_commit_sequencer_pkg;

  localparam int ROB_ADDR_WIDTH = 32;
  localparam int ROB_TAG_WIDTH  = 6;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DSLOT  = 2'd1,
    FREEZE = 2'd2
  } commit_state_t;

  // Same encoding as the branch-prediction outcome type
  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } br_outcome_t;

  function automatic logic is_ctl(input logic is_branch, input logic is_jr);
    return is_branch | is_jr;
  endfunction

endpackage

// File: rtl/rob_commit_sequencer.sv
// ROB-head commit sequencer: one retirement per cycle, MIPS delay-slot ordering,
// freeze after a mispredicted branch or any JR until flush. Optional counters: COMMIT_STATS_EN.
module rob_commit_sequencer
  import rob_commit_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = ROB_ADDR_WIDTH,
  parameter int TAG_WIDTH  = ROB_TAG_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  head_valid,
  input  logic                  head_done,
  input  logic [TAG_WIDTH-1:0]  head_tag,
  input  logic                  head_is_branch,
  input  logic                  head_taken,
  input  logic                  head_is_jr,
  input  logic [ADDR_WIDTH-1:0] head_jr_target,
  input  logic                  head_is_store,
  input  logic                  store_stall,
  input  logic                  mispredict,
  input  logic                  flush,
  output logic                  head_pop,
  output logic                  valid_commit,
  output logic [TAG_WIDTH-1:0]  commit_tag,
  output logic                  valid_branch,
  output logic                  branch_outcome,
  output logic                  valid_jump_reg,
  output logic [ADDR_WIDTH-1:0] jump_target,
`ifdef COMMIT_STATS_EN
  output logic [31:0]           stat_commits,
  output logic [31:0]           stat_branches,
  output logic [31:0]           stat_jr,
  output logic [31:0]           stat_freeze_cycles,
`endif
  output logic                  ds_ctl_err
);

  commit_state_t state_r, state_next_s;
  logic mp_latched_r, mp_latched_next_s;
  logic owner_jr_r;
  logic can_retire_s, pop_ctl_s, pop_slot_s;

  // Retire decision, FSM next state and mispredict latch update
  always_comb begin
    state_next_s      = state_r;
    mp_latched_next_s = mp_latched_r;
    can_retire_s      = head_valid & head_done & ~(head_is_store & store_stall);
    head_pop          = can_retire_s & ~flush & (state_r != FREEZE);
    pop_ctl_s         = head_pop & (state_r == RUN) & is_ctl(head_is_branch, head_is_jr);
    pop_slot_s        = head_pop & (state_r == DSLOT);
    if (flush) begin
      state_next_s      = RUN;
      mp_latched_next_s = 1'b0;
    end else begin
      if (pop_slot_s) begin
        mp_latched_next_s = 1'b0;
      end else if (valid_branch) begin
        mp_latched_next_s = mispredict;
      end else begin
        mp_latched_next_s = mp_latched_r;
      end
      case (state_r)
        RUN: begin
          if (pop_ctl_s) state_next_s = DSLOT;
          else           state_next_s = RUN;
        end
        DSLOT: begin
          if (pop_slot_s) begin
            // Verdict may still be on the wire if the slot pops right behind its branch
            if (mp_latched_r | (valid_branch & mispredict) | owner_jr_r) state_next_s = FREEZE;
            else                                                        state_next_s = RUN;
          end else begin
            state_next_s = DSLOT;
          end
        end
        FREEZE:  state_next_s = FREEZE;
        default: state_next_s = RUN;
      endcase
    end
  end

  // State, latch and registered commit-side pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= RUN;
      mp_latched_r   <= 1'b0;
      owner_jr_r     <= 1'b0;
      valid_commit   <= 1'b0;
      commit_tag     <= '0;
      valid_branch   <= 1'b0;
      branch_outcome <= NOT_TAKEN;
      valid_jump_reg <= 1'b0;
      jump_target    <= '0;
      ds_ctl_err     <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      mp_latched_r   <= mp_latched_next_s;
      owner_jr_r     <= pop_ctl_s ? (head_is_jr & ~head_is_branch) : owner_jr_r;
      valid_commit   <= head_pop;
      commit_tag     <= head_pop ? head_tag : '0;
      valid_branch   <= pop_ctl_s & head_is_branch;
      branch_outcome <= pop_ctl_s & head_is_branch & head_taken;
      valid_jump_reg <= pop_ctl_s & head_is_jr & ~head_is_branch;
      jump_target    <= (pop_ctl_s & head_is_jr & ~head_is_branch) ? head_jr_target : '0;
      ds_ctl_err     <= ds_ctl_err | (pop_slot_s & is_ctl(head_is_branch, head_is_jr));
    end
  end

`ifdef COMMIT_STATS_EN
  // Event counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_commits       <= 32'd0;
      stat_branches      <= 32'd0;
      stat_jr            <= 32'd0;
      stat_freeze_cycles <= 32'd0;
    end else begin
      stat_commits       <= stat_commits + {31'd0, valid_commit};
      stat_branches      <= stat_branches + {31'd0, valid_branch};
      stat_jr            <= stat_jr + {31'd0, valid_jump_reg};
      stat_freeze_cycles <= stat_freeze_cycles + {31'd0, (state_r == FREEZE)};
    end
  end

`ifdef SIMULATION
  event stats_event;
  always @(posedge clk) begin
    if (rst_n && (valid_commit || valid_branch || valid_jump_reg || (state_r == FREEZE)))
      -> stats_event;
  end
`endif
`endif

endmodule

// File: tb/tb_rob_commit_sequencer.sv
// Directed scoreboard bench for rob_commit_sequencer: per-cycle expected commit
// records are queued at drive time and compared one cycle later.
module tb_rob_commit_sequencer;
  import rob_commit_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        head_valid, head_done, head_is_branch, head_taken, head_is_jr;
  logic        head_is_store, store_stall, mispredict, flush;
  logic [5:0]  head_tag;
  logic [31:0] head_jr_target;
  logic        head_pop, valid_commit, valid_branch, branch_outcome, valid_jump_reg, ds_ctl_err;
  logic [5:0]  commit_tag;
  logic [31:0] jump_target;
`ifdef COMMIT_STATS_EN
  logic [31:0] stat_commits, stat_branches, stat_jr, stat_freeze_cycles;
`endif

  typedef struct packed {
    logic        vc;
    logic [5:0]  tag;
    logic        vb;
    logic        bo;
    logic        vj;
    logic [31:0] jt;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;
  logic exp_err = 1'b0;

  rob_commit_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .head_valid(head_valid), .head_done(head_done), .head_tag(head_tag),
    .head_is_branch(head_is_branch), .head_taken(head_taken), .head_is_jr(head_is_jr),
    .head_jr_target(head_jr_target), .head_is_store(head_is_store),
    .store_stall(store_stall), .mispredict(mispredict), .flush(flush),
    .head_pop(head_pop), .valid_commit(valid_commit), .commit_tag(commit_tag),
    .valid_branch(valid_branch), .branch_outcome(branch_outcome),
    .valid_jump_reg(valid_jump_reg), .jump_target(jump_target),
`ifdef COMMIT_STATS_EN
    .stat_commits(stat_commits), .stat_branches(stat_branches),
    .stat_jr(stat_jr), .stat_freeze_cycles(stat_freeze_cycles),
`endif
    .ds_ctl_err(ds_ctl_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_head(input logic v, input logic d, input logic [5:0] tag, input logic br,
                          input logic tk, input logic jr, input logic [31:0] tgt, input logic st);
    head_valid = v; head_done = d; head_tag = tag; head_is_branch = br; head_taken = tk;
    head_is_jr = jr; head_jr_target = tgt; head_is_store = st;
  endtask

  // One cycle: inputs already driven; exp_ctl says a branch/JR pulse is expected for this pop
  task automatic tick(input logic exp_pop, input logic exp_ctl);
    exp_t e, got;
    #1;
    check("head_pop", 64'(head_pop), 64'(exp_pop));
    e = '0;
    if (exp_pop) begin
      e.vc  = 1'b1;
      e.tag = head_tag;
      e.vb  = exp_ctl & head_is_branch;
      e.bo  = exp_ctl & head_is_branch & head_taken;
      e.vj  = exp_ctl & head_is_jr & ~head_is_branch;
      e.jt  = (exp_ctl & head_is_jr & ~head_is_branch) ? head_jr_target : 32'd0;
    end
    e.err = exp_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = {valid_commit, commit_tag, valid_branch, branch_outcome, valid_jump_reg, jump_target, ds_ctl_err};
    e = sb.pop_front();
    check("commit_outputs", 64'(got), 64'(e));
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; store_stall = 1'b0; mispredict = 1'b0; flush = 1'b0;
    set_head(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("reset_state", 64'(dut.state_r), 64'(RUN));
    rst_n = 1'b1;

    // Three back-to-back ALU ops
    for (int i = 1; i <= 3; i++) begin
      set_head(1'b1, 1'b1, 6'(i), 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      tick(1'b1, 1'b0);
    end

    // Mispredicted taken branch -> slot commits, freeze until flush
    set_head(1'b1, 1'b1, 6'd4, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    tick(1'b1, 1'b1);
    set_head(1'b1, 1'b1, 6'd5, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    mispredict = 1'b1;
    tick(1'b1, 1'b0);
    mispredict = 1'b0;
    check("freeze_after_mp", 64'(dut.state_r), 64'(FREEZE));
    set_head(1'b1, 1'b1, 6'd6, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    flush = 1'b1;
    tick(1'b0, 1'b0);
    flush = 1'b0;
    check("run_after_flush", 64'(dut.state_r), 64'(RUN));
    tick(1'b1, 1'b0);

    // Correctly predicted not-taken branch: no freeze
    set_head(1'b1, 1'b1, 6'd7, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(1'b1, 1'b1);
    set_head(1'b1, 1'b1, 6'd8, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(1'b1, 1'b0);
    set_head(1'b1, 1'b1, 6'd9, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(1'b1, 1'b0);
    check("no_freeze_good_pred", 64'(dut.state_r), 64'(RUN));

    // JR: target pulse, freeze after its slot
    set_head(1'b1, 1'b1, 6'd10, 1'b0, 1'b0, 1'b1, 32'h0040_0100, 1'b0);
    tick(1'b1, 1'b1);
    set_head(1'b1, 1'b1, 6'd11, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(1'b1, 1'b0);
    set_head(1'b1, 1'b1, 6'd12, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(1'b0, 1'b0);
    check("freeze_after_jr", 64'(dut.state_r), 64'(FREEZE));
    flush = 1'b1;
    tick(1'b0, 1'b0);
    flush = 1'b0;
    tick(1'b1, 1'b0);

    // Mispredict with a store slot stalled 4 cycles
    set_head(1'b1, 1'b1, 6'd13, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    tick(1'b1, 1'b1);
    set_head(1'b1, 1'b1, 6'd14, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    store_stall = 1'b1;
    mispredict = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0);
      mispredict = 1'b0;
      check("mp_latched_held", 64'(dut.mp_latched_r), 64'd1);
      check("dslot_held", 64'(dut.state_r), 64'(DSLOT));
    end
    store_stall = 1'b0;
    tick(1'b1, 1'b0);
    check("freeze_after_store_slot", 64'(dut.state_r), 64'(FREEZE));
    set_head(1'b1, 1'b1, 6'd15, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(1'b0, 1'b0);
    flush = 1'b1;
    tick(1'b0, 1'b0);
    flush = 1'b0;
    tick(1'b1, 1'b0);

    // Branch inside a JR delay slot: error flag, no branch pulse; reset during freeze
    set_head(1'b1, 1'b1, 6'd16, 1'b0, 1'b0, 1'b1, 32'h0040_0200, 1'b0);
    tick(1'b1, 1'b1);
    set_head(1'b1, 1'b1, 6'd17, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    exp_err = 1'b1;
    tick(1'b1, 1'b0);
    set_head(1'b1, 1'b1, 6'd18, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(1'b0, 1'b0);
    check("freeze_before_reset", 64'(dut.state_r), 64'(FREEZE));
    rst_n = 1'b0;
    exp_err = 1'b0;
    tick(1'b0, 1'b0);
    check("reset_mid_freeze", 64'(dut.state_r), 64'(RUN));
    rst_n = 1'b1;
    tick(1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
